// File: rtl/sms4_pkg.sv
// sms4_pkg: shared constants and helpers for the iterative SMS4 (SM4) core.
//   state_e : controller states
//   SBOX    : byte substitution table used by tau
//   FK, CK  : key-schedule system and round constants
//   rotl32  : 32-bit rotate-left
package sms4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_KEXP  = 2'd1,
    ST_CRYPT = 2'd2
  } state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  localparam logic [31:0] FK [4] = '{
    32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc
  };

  localparam logic [31:0] CK [32] = '{
    32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
    32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
    32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
    32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
    32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
    32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
    32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
    32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
  };

  localparam logic [127:0] FK_WORD = {FK[0], FK[1], FK[2], FK[3]};

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/sms4_tau.sv
// sms4_tau: SMS4 nonlinear layer, one S-box lookup per byte, combinational.
//   a_i : 32-bit input word
//   b_o : substituted word
module sms4_tau
  import sms4_pkg::*;
(
  input  logic [31:0] a_i,
  output logic [31:0] b_o
);

  assign b_o = {SBOX[a_i[31:24]], SBOX[a_i[23:16]], SBOX[a_i[15:8]], SBOX[a_i[7:0]]};

endmodule

// File: rtl/ars_sms4.sv
// ars_sms4: iterative SMS4 cipher, one round per clock, with stored round keys.
//   clk, reset    : clock, synchronous active-high reset
//   kin, kvld, load : master key, key control, key-load request
//   din, enc, start : input block, direction, block request
//   kout, kstr    : final key-schedule words and completion pulse
//   dout, ready   : result block and completion pulse
//   busy          : expansion or cipher rounds in progress
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting; accepts key load (priority) or block request
// ST_KEXP  | rounds 0..31 produce rk_i; step 32 publishes kout/kstr
// ST_CRYPT | rounds 0..31 update X; step 32 publishes dout/ready
module ars_sms4
  import sms4_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] kin,
  input  logic [127:0] din,
  input  logic         start,
  input  logic         enc,
  input  logic         load,
  input  logic [1:0]   kvld,
  output logic [127:0] kout,
  output logic [127:0] dout,
  output logic         busy,
  output logic         ready,
  output logic         kstr
);

  state_e         state_q, state_d;
  logic [5:0]     rnd_q, rnd_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   x_q, x_d;
  logic           enc_q, enc_d;
  logic           kvalid_q, kvalid_d;
  logic [127:0]   kout_q, kout_d;
  logic [127:0]   dout_q, dout_d;
  logic           ready_q, ready_d;
  logic           kstr_q, kstr_d;
  logic           rk_we;
  logic           accept_en;
  logic [31:0]    rkf_q [32];

  logic [31:0]    k_tin, k_tout, rk_new;
  logic [31:0]    x_tin, x_tout, x_new;
  logic [4:0]     rk_idx;
  logic [31:0]    rk_sel;

  assign k_tin  = key_q[95:64] ^ key_q[63:32] ^ key_q[31:0] ^ CK[rnd_q[4:0]];
  assign rk_new = key_q[127:96] ^ k_tout ^ rotl32(k_tout, 13) ^ rotl32(k_tout, 23);

  // Decryption walks the same key file backwards.
  assign rk_idx = enc_q ? rnd_q[4:0] : (5'd31 - rnd_q[4:0]);
  assign rk_sel = rkf_q[rk_idx];
  assign x_tin  = x_q[95:64] ^ x_q[63:32] ^ x_q[31:0] ^ rk_sel;
  assign x_new  = x_q[127:96] ^ x_tout ^ rotl32(x_tout, 2) ^ rotl32(x_tout, 10)
                ^ rotl32(x_tout, 18) ^ rotl32(x_tout, 24);

  sms4_tau u_tau_key (
    .a_i (k_tin),
    .b_o (k_tout)
  );

  sms4_tau u_tau_data (
    .a_i (x_tin),
    .b_o (x_tout)
  );

  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    key_d     = key_q;
    x_d       = x_q;
    enc_d     = enc_q;
    kvalid_d  = kvalid_q;
    kout_d    = kout_q;
    dout_d    = dout_q;
    ready_d   = 1'b0;
    kstr_d    = 1'b0;
    rk_we     = 1'b0;
    accept_en = 1'b0;

    case (state_q)
      ST_IDLE: accept_en = 1'b1;
      ST_KEXP: begin
        if (rnd_q == 6'd32) begin
          kvalid_d  = 1'b1;
          kout_d    = key_q;
          kstr_d    = 1'b1;
          state_d   = ST_IDLE;
          accept_en = 1'b1;
        end else begin
          rk_we = 1'b1;
          key_d = {key_q[95:0], rk_new};
          rnd_d = rnd_q + 6'd1;
        end
      end
      ST_CRYPT: begin
        if (rnd_q == 6'd32) begin
          dout_d    = {x_q[31:0], x_q[63:32], x_q[95:64], x_q[127:96]};
          ready_d   = 1'b1;
          state_d   = ST_IDLE;
          accept_en = 1'b1;
        end else begin
          x_d   = {x_q[95:0], x_new};
          rnd_d = rnd_q + 6'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The completion step doubles as an idle cycle so back-to-back work loses
    // no clock; kvalid_d already reflects a key finishing on this same edge.
    if (accept_en) begin
      if (load && (kvld == 2'b01)) begin
        key_d    = kin ^ FK_WORD;
        kvalid_d = 1'b0;
        rnd_d    = '0;
        state_d  = ST_KEXP;
      end else if (start && kvld[1] && kvalid_d) begin
        x_d     = din;
        enc_d   = enc;
        rnd_d   = '0;
        state_d = ST_CRYPT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rnd_q    <= '0;
      key_q    <= '0;
      x_q      <= '0;
      enc_q    <= 1'b0;
      kvalid_q <= 1'b0;
      kout_q   <= '0;
      dout_q   <= '0;
      ready_q  <= 1'b0;
      kstr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      key_q    <= key_d;
      x_q      <= x_d;
      enc_q    <= enc_d;
      kvalid_q <= kvalid_d;
      kout_q   <= kout_d;
      dout_q   <= dout_d;
      ready_q  <= ready_d;
      kstr_q   <= kstr_d;
    end
  end

  // Round keys survive reset; kvalid_q guards their use.
  always_ff @(posedge clk) begin
    if (rk_we) rkf_q[rnd_q[4:0]] <= rk_new;
  end

  assign busy  = (state_q != ST_IDLE);
  assign ready = ready_q;
  assign kstr  = kstr_q;
  assign kout  = kout_q;
  assign dout  = dout_q;

endmodule

// File: tb/tb_ars_sms4.sv
// tb_ars_sms4: self-checking bench for ars_sms4 using a vector table, a
// scoreboard queue of expected completions and directed corner sequences.
module tb_ars_sms4;

  logic         clk;
  logic         reset;
  logic [127:0] kin;
  logic [127:0] din;
  logic         start;
  logic         enc;
  logic         load;
  logic [1:0]   kvld;
  logic [127:0] kout;
  logic [127:0] dout;
  logic         busy;
  logic         ready;
  logic         kstr;

  ars_sms4 dut (
    .clk   (clk),
    .reset (reset),
    .kin   (kin),
    .din   (din),
    .start (start),
    .enc   (enc),
    .load  (load),
    .kvld  (kvld),
    .kout  (kout),
    .dout  (dout),
    .busy  (busy),
    .ready (ready),
    .kstr  (kstr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] KEY0 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT0  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT0  = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] M32  = 128'h0000000000000000000000000000ffffffff;

  typedef struct {
    logic         is_key;
    logic         chk;
    logic [127:0] val;
    logic [127:0] mask;
    string        name;
  } exp_t;

  typedef struct {
    logic         is_key;
    logic         e;
    logic [127:0] k;
    logic [127:0] d;
    logic [127:0] exp;
    logic [127:0] mask;
    string        name;
  } vec_t;

  exp_t         sb [$];
  vec_t         vt [4];
  int           nvec = 0;
  int           nerr = 0;
  logic [127:0] last_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic st, input logic e, input logic [1:0] kv,
                       input logic [127:0] k, input logic [127:0] d);
    load  = ld;
    start = st;
    enc   = e;
    kvld  = kv;
    kin   = k;
    din   = d;
  endtask

  task automatic push(input logic is_key, input logic chk, input logic [127:0] val,
                      input logic [127:0] mask, input string name);
    exp_t e;
    e.is_key = is_key;
    e.chk    = chk;
    e.val    = val;
    e.mask   = mask;
    e.name   = name;
    sb.push_back(e);
  endtask

  // Called just after the accept edge (or 'already' cycles later); waits for
  // the completion pulse, checks latency/busy and pops the scoreboard.
  task automatic finish_op(input string name, input int already, input logic exp_idle);
    exp_t         e;
    int           lat = 0;
    logic         busy_ok = 1'b1;
    logic [127:0] act;
    if (!busy) busy_ok = 1'b0;
    for (int n = already + 1; n <= 40; n++) begin
      tick();
      if (ready || kstr) begin
        lat = n;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    check({name, " latency"}, 128'(lat), 128'd33);
    check({name, " busy span"}, {127'd0, busy_ok}, 128'd1);
    if (sb.size() == 0) begin
      nvec++;
      nerr++;
      $display("FAIL %s scoreboard: got empty queue expected entry", name);
    end else begin
      e = sb.pop_front();
      if (lat != 0) begin
        check({name, " busy after"}, {127'd0, busy}, {127'd0, ~exp_idle});
        check({name, " pulse kind"}, {126'd0, ready, kstr}, e.is_key ? 128'd1 : 128'd2);
        act = e.is_key ? kout : dout;
        last_out = act;
        if (e.chk) check({name, " value"}, act & e.mask, e.val & e.mask);
      end
    end
  endtask

  task automatic pulse_gone(input string name, input logic exp_busy);
    tick();
    check({name, " pulse width"}, {125'd0, busy, ready, kstr}, {125'd0, exp_busy, 2'b00});
  endtask

  task automatic quiet(input string name, input int ncyc);
    logic seen = 1'b0;
    for (int n = 0; n < ncyc; n++) begin
      tick();
      if (busy || ready || kstr) seen = 1'b1;
    end
    check({name, " ignored"}, {127'd0, seen}, 128'd0);
  endtask

  initial begin
    logic [127:0] rkey, rblk, ct;

    vt[0] = '{1'b1, 1'b0, KEY0, '0,  M32 & 128'h9124a012, M32,  "key load"};
    vt[1] = '{1'b0, 1'b1, '0,   PT0, CT0,                 '1,   "encrypt"};
    vt[2] = '{1'b0, 1'b0, '0,   CT0, PT0,                 '1,   "decrypt"};
    vt[3] = '{1'b0, 1'b1, '0,   PT0, CT0,                 '1,   "encrypt repeat"};

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
    tick();
    tick();
    reset = 1'b0;
    check("reset flags", {125'd0, busy, ready, kstr}, 128'd0);
    check("reset kout", kout, 128'd0);
    check("reset dout", dout, 128'd0);

    drive(1'b0, 1'b1, 1'b1, 2'b11, '0, PT0);
    quiet("start without key", 40);

    for (int i = 0; i < 4; i++) begin
      push(vt[i].is_key, 1'b1, vt[i].exp, vt[i].mask, vt[i].name);
      if (vt[i].is_key) drive(1'b1, 1'b0, 1'b0, 2'b01, vt[i].k, '0);
      else              drive(1'b0, 1'b1, vt[i].e, 2'b11, '0, vt[i].d);
      tick();
      drive(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
      finish_op(vt[i].name, 0, 1'b1);
      if (vt[i].is_key) check("rk0", 128'(dut.rkf_q[0]), 128'hf12186f9);
      pulse_gone(vt[i].name, 1'b0);
    end

    drive(1'b0, 1'b1, 1'b1, 2'b00, '0, PT0);
    quiet("kvld 00", 10);
    drive(1'b0, 1'b1, 1'b1, 2'b01, '0, PT0);
    quiet("kvld 01 start", 10);

    for (int r = 0; r < 3; r++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      rblk = {$urandom, $urandom, $urandom, $urandom};
      push(1'b1, 1'b0, '0, '0, "rand key");
      drive(1'b1, 1'b0, 1'b0, 2'b01, rkey, '0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
      finish_op("rand key", 0, 1'b1);
      if (r == 0) check("dout kept over key load", dout, CT0);
      push(1'b0, 1'b0, '0, '0, "rand enc");
      drive(1'b0, 1'b1, 1'b1, 2'b11, '0, rblk);
      tick();
      drive(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
      finish_op("rand enc", 0, 1'b1);
      ct = last_out;
      check("rand enc not identity", {127'd0, ct == rblk}, 128'd0);
      push(1'b0, 1'b1, rblk, '1, "rand dec");
      drive(1'b0, 1'b1, 1'b0, 2'b11, '0, ct);
      tick();
      drive(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
      finish_op("rand dec", 0, 1'b1);
    end

    push(1'b1, 1'b1, M32 & 128'h9124a012, M32, "combo key");
    push(1'b0, 1'b1, CT0, '1, "combo enc");
    drive(1'b1, 1'b1, 1'b1, 2'b01, KEY0, PT0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 2'b11, '0, PT0);
    finish_op("combo key", 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
    pulse_gone("combo", 1'b1);
    finish_op("combo enc", 1, 1'b1);

    push(1'b0, 1'b1, CT0, '1, "retrigger 1");
    push(1'b0, 1'b1, CT0, '1, "retrigger 2");
    drive(1'b0, 1'b1, 1'b1, 2'b11, '0, PT0);
    tick();
    finish_op("retrigger 1", 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
    finish_op("retrigger 2", 0, 1'b1);
    pulse_gone("retrigger", 1'b0);

    drive(1'b0, 1'b1, 1'b1, 2'b11, '0, PT0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
    for (int n = 0; n < 15; n++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort flags", {125'd0, busy, ready, kstr}, 128'd0);
    check("abort kout", kout, 128'd0);
    check("abort dout", dout, 128'd0);
    check("abort state", 128'(dut.state_q), 128'(sms4_pkg::ST_IDLE));
    sb.delete();
    drive(1'b0, 1'b1, 1'b1, 2'b11, '0, PT0);
    quiet("start after abort", 40);

    push(1'b1, 1'b1, M32 & 128'h9124a012, M32, "reload key");
    drive(1'b1, 1'b0, 1'b0, 2'b01, KEY0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
    finish_op("reload key", 0, 1'b1);
    push(1'b0, 1'b1, PT0, '1, "reload dec");
    drive(1'b0, 1'b1, 1'b0, 2'b11, '0, CT0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
    finish_op("reload dec", 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ars_sms4.md
# ars_sms4

Iterative SMS4 (SM4) 128-bit block cipher core with on-chip key expansion. It processes one round per clock and stores all 32 round keys, so encryption and decryption take the same time. It sits behind a simple load/start register interface in the crypto datapath. A key is expanded once and then reused for any number of blocks.

## Interface

Parameters: none.

- `clk`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- `kin`  in  128  master key; bits [127:96] = MK0 … [31:0] = MK3
- `din`  in  128  input block; bits [127:96] = X0 … [31:0] = X3
- `start`  in  1  request a block operation (level; sampled when idle)
- `enc`  in  1  1 = encrypt, 0 = decrypt; sampled with `start`
- `load`  in  1  request key load (level; sampled when idle)
- `kvld`  in  2  key control: 2'b01 = new key on `kin`; kvld[1]=1 = use stored key
- `kout`  out  128  final key-schedule state {rk28,rk29,rk30,rk31}
- `dout`  out  128  result block {X35,X34,X33,X32}
- `busy`  out  1  expansion or cipher rounds in progress
- `ready`  out  1  one-cycle pulse: `dout` updated
- `kstr`  out  1  one-cycle pulse: key expansion done, `kout` updated

## Operation

- States: IDLE, KEXP (32 cycles), CRYPT (32 cycles).
- In IDLE, key load is accepted when `load`=1 and `kvld`=2'b01:
  - Capture K0..K3 = MK ^ FK.
  - Clear the key-valid flag.
  - Enter KEXP.
- In IDLE, a block is accepted when `start`=1, `kvld[1]`=1, the key-valid flag is set, and no key load is accepted in the same cycle. Key load has priority.
  - Capture X0..X3 from `din` and latch `enc`.
  - Enter CRYPT.
- KEXP round i (0..31): rk_i = K_i ^ T'(K_{i+1}^K_{i+2}^K_{i+3}^CK_i), with T' = L'(τ(·)) and L'(B) = B ^ (B<<<13) ^ (B<<<23).
  - Write rk_i into the 32×32 round-key file.
  - Shift the key state.
  - After i=31: set key-valid, load `kout`, pulse `kstr`, return to IDLE.
- CRYPT round i: X_{i+4} = X_i ^ T(X_{i+1}^X_{i+2}^X_{i+3}^rk), with T = L(τ(·)) and L(B) = B ^ B<<<2 ^ B<<<10 ^ B<<<18 ^ B<<<24.
  - rk = rk_i when encrypting, rk_{31-i} when decrypting.
  - After i=31: `dout` = {X35,X34,X33,X32}, pulse `ready`, return to IDLE.
- τ applies the standard SM4 S-box to each byte.
- `start` and `load` held high re-trigger from IDLE. Repeated blocks with unchanged `din` give an identical `dout`.
- Inputs are ignored while `busy`=1. A new key load does not disturb `dout`.
- `kvld`=2'b00, or `kvld[1]`=1 with the key-valid flag clear: `start` is ignored.

## Timing

- Reset values:
  - `busy`, `ready`, `kstr` = 0
  - `kout`, `dout` = 0
  - key-valid flag = 0; state = IDLE
- Reset in mid-operation aborts and returns to IDLE with the reset values above. The round-key file contents need not be cleared.
- An operation accepted at edge t:
  - `busy`=1 from cycle t+1 through t+32.
  - At edge t+33, `busy` falls, the result register updates, and `ready`/`kstr` is high for exactly one cycle.
  - A new operation can be accepted at that same edge t+33.
- Latency from accept to result is 33 cycles, identical for encrypt, decrypt, and key expansion.
- `dout`/`kout` hold their values until the next completion of the same kind.

## Structure

- Package `sms4_pkg` holds:
  - S-box[256] constant
  - FK[4] and CK[32] constants
  - state enum
  - rotate-left helper function
- One sub-module, `sms4_tau`: 32-bit input, four parallel S-box lookups, combinational. Instantiate it twice, once for key expansion and once for the data path; they may be shared.
- The round-key file is 32 × 32 flops, written in KEXP and read in CRYPT.

## Test plan

- Key load: `kin`=0123456789abcdeffedcba9876543210, `kvld`=01, `load`=1.
  - After 33 cycles: `kstr` pulses once and `kout[31:0]`=9124a012 (rk31).
  - Internal rk0 = f12186f9.
- Encrypt after that key: `din`=0123456789abcdeffedcba9876543210, `enc`=1, `kvld`=11, `start`=1.
  - `dout`=681edf34d206965e86b3e94f536e4246.
  - `ready` pulses 33 cycles after accept.
- Decrypt with the same key: `din`=681edf34d206965e86b3e94f536e4246, `enc`=0.
  - `dout`=0123456789abcdeffedcba9876543210.
- `start`=1 with `kvld`=11 before any key is loaded: no `busy`, no `ready`.
- `load` (`kvld`=01) and `start` both asserted in IDLE: key expansion runs first.
  - The block starts at the kstr cycle and finishes 33 cycles later.
- Assert `reset` at round 15 of CRYPT.
  - Next cycle: all outputs 0 and state IDLE.
  - A following `start` is ignored until the key is reloaded.
